seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Run-time controller for serial sequence detection. Arms a programmable-pattern matcher on a
//  start command, feeds it a valid-qualified bit stream, counts matches up to a target and
//  reports done. Supersedes fixed-pattern detectors; sits between CSR/config logic and the stream.
// PARAMETERS
//  PAT_W  8   max pattern length in bits (2..15)
//  CNT_W  8   width of match counter and cfg_target
//  TO_W   16  width of timeout counter (only with SEQ_CTRL_TIMEOUT_EN)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-low; all state/outputs cleared on assertion
//  start        in   1      begin a run (sampled in IDLE only)
//  abort        in   1      terminate run, return to IDLE
//  cfg_pattern  in   PAT_W  pattern; cfg_pattern[cfg_len-1] = oldest bit, [0] = newest
//  cfg_len      in   4      pattern length, legal 1..PAT_W
//  cfg_overlap  in   1      1 = overlapping matches counted; 0 = history restarts after match
//  cfg_target   in   CNT_W  matches required for done, legal >=1
//  bit_valid    in   1      bit_in qualifier
//  bit_in       in   1      serial data
//  busy         out  1      state != IDLE
//  match        out  1      1-cycle pulse per detected match
//  match_cnt    out  CNT_W  matches in current/last run; holds until next accepted start
//  done         out  1      1-cycle pulse, target reached
//  err          out  1      1-cycle pulse, start rejected for illegal config
// BEHAVIOUR
//  Reset: state=IDLE; busy, match, done, err, match_cnt, history, fill all 0.
//  FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  IDLE: start & ~abort & legal cfg -> LOAD. Illegal (cfg_len==0, cfg_len>PAT_W, cfg_target==0)
//   -> err=1 next cycle, stay IDLE. abort same cycle as start: abort wins, nothing happens.
//  LOAD (1 cycle): latch cfg_* into shadow regs; clear history, fill, match_cnt. Bits ignored.
//   cfg_* changes after LOAD do not affect the run.
//  RUN: on bit_valid, history <= {history[PAT_W-2:0], bit_in}; fill = min(fill+1, len).
//   Match when new fill==len and new history[len-1:0]==pattern[len-1:0].
//   Match registered: match=1 and match_cnt+1 on the edge after the completing bit.
//   cfg_overlap=0: fill cleared to 0 on match (history kept, ignored). bit_valid=0: no change.
//   Final match (match_cnt+1==target): same edge enters DONE.
//  DONE (1 cycle): done=1, coincident with final match pulse; busy still 1; -> IDLE.
//  abort in LOAD/RUN: -> IDLE next edge; no done; match_cnt holds; bit in that cycle ignored.
//  abort in DONE: ignored (done still pulses). start while busy: ignored.
//  match_cnt never wraps (run ends at target <= 2^CNT_W-1).
//  Reset mid-run: immediate asynchronous clear; outputs 0 without waiting for clk.
// CONFIGURATION
//  SEQ_CTRL_TIMEOUT_EN defined: extra port cfg_timeout in TO_W and output timeout out 1.
//   RUN counts accepted bits since LOAD or last match; count reaching cfg_timeout (!=0) ->
//   timeout=1 for 1 cycle, -> IDLE, no done, match_cnt holds. cfg_timeout==0 disables.
//   A match on the bit that would time out wins (counter cleared, no timeout).
//  Undefined: ports absent, no timeout counter; runs only end by target or abort.
// STRUCTURE
//  Package seq_ctrl_pkg: FSM state encoding (IDLE/LOAD/RUN/DONE), LEN_W=4, legality check fn.
//  Sub-module seq_pattern_match: history shift reg, fill counter, masked compare -> hit.
//  Top holds FSM, shadow config, match counter, output regs, optional timeout counter.
// TESTING
//  1 pat=3'b110 len=3 ovl=0 tgt=2, bits 1,1,0,1,1,0 -> match after bit3, bit6; cnt=2; done w/ 2nd.
//  2 pat=2'b11 len=2 tgt=3, bits 1,1,1,1: ovl=1 -> matches bits 2,3,4 + done; ovl=0 -> bits 2,4, busy.
//  3 start with len=0, len=9, tgt=0 -> err pulse each, busy stays 0, match_cnt unchanged.
//  4 pat=110 tgt=3, abort after 1 match -> IDLE next edge, cnt=1 holds, done never; bit_valid gaps
//    between 1,1,0 bits do not break the match.
//  5 reset low mid-RUN between edges -> busy/match/cnt 0 immediately; new start works after release.
//  6 (TIMEOUT_EN) cfg_timeout=4, pat=110, bits 0,0,0,0 -> timeout after bit4, IDLE, done=0.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial sequence-detect controller.
//   - FSM state encoding (legacy-compatible localparams)
//   - LEN_W: width of the pattern-length field
//   - cfg_legal(): start-time configuration legality check
package seq_ctrl_pkg;

  localparam int unsigned LEN_W = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // A run needs a non-empty pattern that fits the matcher and a non-zero target.
  function automatic logic cfg_legal(input logic [LEN_W-1:0] len,
                                     input int unsigned      max_len,
                                     input logic             target_zero);
    return (len != '0) && (32'(len) <= max_len) && !target_zero;
  endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// Programmable-pattern matcher: history shift register, fill counter and masked compare.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   clear            clear history and fill (run load)
//   shift_en         accept bit_in this cycle
//   bit_in           serial data
//   pattern, len     pattern bits ([len-1] oldest, [0] newest) and length
//   overlap          1: keep fill after a hit, 0: restart fill after a hit
//   hit              combinational: the bit being accepted completes a match
module seq_pattern_match
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_new, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_new;

  always_comb begin
    hist_new = {hist_q[PAT_W-2:0], bit_in};
    fill_new = (fill_q >= len) ? len : fill_q + 1'b1;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (fill_new == len) && (((hist_new ^ pattern) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_new;
      // Without overlap the old history stays but is ignored until refilled.
      fill_d = (hit && !overlap) ? '0 : fill_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time controller for serial sequence detection.
// Arms the pattern matcher on start, counts matches up to a target and pulses done.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   start, abort                    run control
//   cfg_pattern/len/overlap/target  run configuration, latched in LOAD
//   bit_valid, bit_in               qualified serial stream
//   busy, match, match_cnt, done    run status
//   err                             start rejected for illegal configuration
// Build option SEQ_CTRL_TIMEOUT_EN adds cfg_timeout/timeout: a run ends when cfg_timeout
// accepted bits pass without a match (cfg_timeout == 0 disables).
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8
`ifdef SEQ_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TO_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             bit_valid,
  input  logic             bit_in,
`ifdef SEQ_CTRL_TIMEOUT_EN
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             timeout,
`endif
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             err
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             shift_en, hit;
`ifdef SEQ_CTRL_TIMEOUT_EN
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Abort pre-empts the bit presented in the same cycle.
  assign shift_en = (state_q == StRun) && bit_valid && !abort;

  seq_pattern_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == StLoad),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .pattern  (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    match_d = 1'b0;
    err_d   = 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
    tmo_d     = tmo_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (cfg_legal(cfg_len, PAT_W, cfg_target == '0)) state_d = StLoad;
          else                                              err_d   = 1'b1;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          pat_d   = cfg_pattern;
          len_d   = cfg_len;
          ovl_d   = cfg_overlap;
          tgt_d   = cfg_target;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SEQ_CTRL_TIMEOUT_EN
          tmo_d    = cfg_timeout;
          to_cnt_d = '0;
`endif
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (hit) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == tgt_q) state_d = StDone;
`ifdef SEQ_CTRL_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
`ifdef SEQ_CTRL_TIMEOUT_EN
        else if (shift_en) begin
          to_cnt_d = to_cnt_q + 1'b1;
          if ((tmo_q != '0) && (to_cnt_d == tmo_q)) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      tmo_q     <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
`ifdef SEQ_CTRL_TIMEOUT_EN
      tmo_q     <= tmo_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign err       = err_q;
`ifdef SEQ_CTRL_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a behavioural model pushes the expected outputs
// for every driven cycle onto a queue; they are popped and compared one edge later.
module tb_seq_detect_ctrl;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             busy, match, done, err;
  logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_CTRL_TIMEOUT_EN
  logic [15:0]      cfg_timeout = '0;
  logic             timeout;
`endif

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
`ifdef SEQ_CTRL_TIMEOUT_EN
    .cfg_timeout (cfg_timeout),
    .timeout     (timeout),
`endif
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .err         (err)
  );

  typedef struct packed {
    logic             busy;
    logic             match;
    logic             done;
    logic             err;
    logic             tmo;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  string phase = "reset";

  // Model state: 0 idle, 1 load, 2 run, 3 done.
  int          m_st = 0;
  int unsigned m_hist = 0, m_fill = 0, m_cnt = 0, m_to = 0;
  int unsigned s_pat = 0, s_len = 0, s_tgt = 0, s_tmo = 0;
  logic        s_ovl = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_hist = 0; m_fill = 0; m_cnt = 0; m_to = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic st, input logic ab, input logic v, input logic b);
    exp_t        e;
    int unsigned lmask;
    e = '0;
    case (m_st)
      0: if (st && !ab) begin
        if (cfg_len != 0 && cfg_len <= PAT_W && cfg_target != 0) m_st = 1;
        else e.err = 1'b1;
      end
      1: if (ab) m_st = 0;
      else begin
        s_pat = cfg_pattern; s_len = cfg_len; s_ovl = cfg_overlap; s_tgt = cfg_target;
`ifdef SEQ_CTRL_TIMEOUT_EN
        s_tmo = cfg_timeout;
`endif
        m_hist = 0; m_fill = 0; m_cnt = 0; m_to = 0; m_st = 2;
      end
      2: if (ab) m_st = 0;
      else if (v) begin
        m_hist = (m_hist << 1) | 32'(b);
        if (m_fill < s_len) m_fill++;
        lmask = (1 << s_len) - 1;
        if (m_fill == s_len && (m_hist & lmask) == (s_pat & lmask)) begin
          e.match = 1'b1;
          m_cnt++;
          m_to = 0;
          if (!s_ovl) m_fill = 0;
          if (m_cnt == s_tgt) m_st = 3;
        end else begin
          m_to++;
          if (s_tmo != 0 && m_to == s_tmo) begin
            e.tmo = 1'b1;
            m_st  = 0;
          end
        end
      end
      default: m_st = 0;
    endcase
    e.busy = (m_st != 0);
    e.done = (m_st == 3);
    e.cnt  = m_cnt[CNT_W-1:0];
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then compare the outputs the DUT produces after the edge.
  task automatic cycle(input logic st, input logic ab, input logic v, input logic b);
    exp_t e;
    start = st; abort = ab; bit_valid = v; bit_in = b;
    model_step(st, ab, v, b);
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("busy", busy, e.busy);
      check_eq("match", match, e.match);
      check_eq("done", done, e.done);
      check_eq("err", err, e.err);
      check_eq("match_cnt", match_cnt, e.cnt);
`ifdef SEQ_CTRL_TIMEOUT_EN
      check_eq("timeout", timeout, e.tmo);
`endif
    end
  endtask

  task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic [7:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
  endtask

  // Start cycle plus LOAD cycle; the LOAD-cycle bit must be ignored.
  task automatic start_run();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic run_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  initial begin
    #12;
    check_eq("busy", busy, 0);
    check_eq("match", match, 0);
    check_eq("done", done, 0);
    check_eq("err", err, 0);
    check_eq("match_cnt", match_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    // Non-overlapping 110 twice; cfg changes after LOAD must not matter.
    phase = "t1";
    set_cfg(8'b110, 4'd3, 1'b0, 8'd2);
    start_run();
    set_cfg(8'hFF, 4'd2, 1'b1, 8'd9);
    run_bits(16'b110110, 6);
    check_eq("final_cnt", match_cnt, 2);
    check_eq("final_done", done, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "t2_ovl";
    set_cfg(8'b11, 4'd2, 1'b1, 8'd3);
    start_run();
    run_bits(16'b1111, 4);
    check_eq("final_cnt", match_cnt, 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "t2_noovl";
    set_cfg(8'b11, 4'd2, 1'b0, 8'd3);
    start_run();
    run_bits(16'b1111, 4);
    check_eq("final_cnt", match_cnt, 2);
    check_eq("still_busy", busy, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);

    phase = "t3";
    set_cfg(8'b11, 4'd0, 1'b0, 8'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b11, 4'd9, 1'b0, 8'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b11, 4'd2, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("err_pulse", err, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_kept", match_cnt, 2);

    // Valid gaps, start while busy, abort with a bit present, start+abort together.
    phase = "t4";
    set_cfg(8'b110, 4'd3, 1'b0, 8'd3);
    start_run();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_bits(16'b110, 3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("cnt_hold", match_cnt, 1);
    check_eq("idle", busy, 0);

    // Asynchronous reset between edges while a match pulse is showing.
    phase = "t5";
    set_cfg(8'b110, 4'd3, 1'b0, 8'd3);
    start_run();
    run_bits(16'b110, 3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_busy", busy, 0);
    check_eq("async_match", match, 0);
    check_eq("async_cnt", match_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    start_run();
    run_bits(16'b110, 3);
    check_eq("restart_cnt", match_cnt, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);

`ifdef SEQ_CTRL_TIMEOUT_EN
    phase = "t6";
    cfg_timeout = 16'd4;
    set_cfg(8'b110, 4'd3, 1'b0, 8'd1);
    start_run();
    run_bits(16'b0000, 4);
    check_eq("to_idle", busy, 0);
    check_eq("to_done", done, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cfg_timeout = 16'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
